// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounced push-button request, walk/clearance/don't-walk lamps.
// Optional audible beep output is built only when PED_AUDIO_EN is defined.
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLEAR_THRESH    = 5,
    parameter int FLASH_DIV       = 2,
    parameter int LOCKOUT_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_button,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic [7:0] clock,
    output logic       pass_request,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_lamp,
    output logic [7:0] ped_count,
    output logic       seq_err
`ifdef PED_AUDIO_EN
    ,
    output logic       beep
`endif
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FL_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WALK,
        S_CLEAR,
        S_LOCKOUT
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        sync_q;
    logic              db_level, db_d;
    logic [DB_W-1:0]   db_cnt;
    logic              red_d;
    logic              pending, pending_nx;
    logic [FL_W-1:0]   flash_cnt, flash_cnt_nx;
    logic              flash_phase, flash_phase_nx;
    logic [LK_W-1:0]   lock_cnt, lock_cnt_nx;
    logic              seq_err_nx;
    logic              press, red_rise, red_fall, lamp_conflict;
    logic              ped_phase_nx;

    assign press         = db_level & ~db_d;
    assign red_rise      = red & ~red_d;
    assign red_fall      = ~red & red_d;
    assign lamp_conflict = (red & yellow) | (red & green) | (yellow & green);
    assign ped_phase_nx  = (state_nx == S_WALK) || (state_nx == S_CLEAR);

    // Button level is only accepted after a full run of identical synchronized samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            db_level <= 1'b0;
            db_d     <= 1'b0;
            db_cnt   <= '0;
            red_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ped_button};
            db_d   <= db_level;
            red_d  <= red;
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_nx       = state;
        pending_nx     = pending;
        flash_cnt_nx   = flash_cnt;
        flash_phase_nx = flash_phase;
        lock_cnt_nx    = lock_cnt;
        seq_err_nx     = lamp_conflict;
        case (state)
            S_IDLE: begin
                if (press) state_nx = S_REQ;
            end
            S_REQ: begin
                if (red_rise) state_nx = S_WALK;
            end
            S_WALK: begin
                pending_nx = pending | press;
                if (red_fall) begin
                    state_nx    = S_LOCKOUT;
                    seq_err_nx  = 1'b1;
                    lock_cnt_nx = '0;
                end else if (clock <= 8'(CLEAR_THRESH)) begin
                    state_nx       = S_CLEAR;
                    flash_cnt_nx   = '0;
                    flash_phase_nx = 1'b1;
                end
            end
            S_CLEAR: begin
                pending_nx = pending | press;
                if (red_fall) begin
                    state_nx       = S_LOCKOUT;
                    lock_cnt_nx    = '0;
                    flash_phase_nx = 1'b0;
                end else if (flash_cnt == FL_W'(FLASH_DIV - 1)) begin
                    flash_cnt_nx   = '0;
                    flash_phase_nx = ~flash_phase;
                end else begin
                    flash_cnt_nx = flash_cnt + FL_W'(1);
                end
            end
            S_LOCKOUT: begin
                // A press arriving on the final lockout cycle still counts as pending.
                if (lock_cnt == LK_W'(LOCKOUT_CYCLES - 1)) begin
                    state_nx    = (pending | press) ? S_REQ : S_IDLE;
                    pending_nx  = 1'b0;
                    lock_cnt_nx = '0;
                end else begin
                    pending_nx  = pending | press;
                    lock_cnt_nx = lock_cnt + LK_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            flash_cnt    <= '0;
            flash_phase  <= 1'b0;
            lock_cnt     <= '0;
            pass_request <= 1'b0;
            walk         <= 1'b0;
            dont_walk    <= 1'b1;
            req_lamp     <= 1'b0;
            ped_count    <= 8'd0;
            seq_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            pending      <= pending_nx;
            flash_cnt    <= flash_cnt_nx;
            flash_phase  <= flash_phase_nx;
            lock_cnt     <= lock_cnt_nx;
            pass_request <= (state_nx == S_REQ);
            walk         <= (state_nx == S_WALK) || ((state_nx == S_CLEAR) && flash_phase_nx);
            dont_walk    <= ~ped_phase_nx;
            req_lamp     <= (state_nx == S_REQ) || pending_nx;
            ped_count    <= ped_phase_nx ? clock : 8'd0;
            seq_err      <= seq_err_nx;
        end
    end

`ifdef PED_AUDIO_EN
    logic [2:0] beep_cnt;

    // Slow beep while walking, fast beep during clearance; restarts on every phase entry.
    always_ff @(posedge clk) begin
        if (rst || !ped_phase_nx) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_nx != state) begin
            beep     <= 1'b1;
            beep_cnt <= '0;
        end else if (beep_cnt == ((state_nx == S_WALK) ? 3'd7 : 3'd1)) begin
            beep     <= ~beep;
            beep_cnt <= '0;
        end else begin
            beep_cnt <= beep_cnt + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios plus randomized lamp/button traffic
// compared every cycle against a behavioural model through an expected-value queue.
module tb_ped_crossing_ctrl;

    localparam int DEB = 4;
    localparam int CT  = 5;
    localparam int FD  = 2;
    localparam int LK  = 3;
    localparam int W   = 13;

    logic       clk = 1'b0;
    logic       rst, ped_button, red, yellow, green;
    logic [7:0] clock;
    logic       pass_request, walk, dont_walk, req_lamp, seq_err;
    logic [7:0] ped_count;
`ifdef PED_AUDIO_EN
    logic       beep;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    ped_crossing_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CLEAR_THRESH(CT),
        .FLASH_DIV(FD),
        .LOCKOUT_CYCLES(LK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ped_button(ped_button),
        .red(red),
        .yellow(yellow),
        .green(green),
        .clock(clock),
        .pass_request(pass_request),
        .walk(walk),
        .dont_walk(dont_walk),
        .req_lamp(req_lamp),
        .ped_count(ped_count),
        .seq_err(seq_err)
`ifdef PED_AUDIO_EN
        ,
        .beep(beep)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_REQ, M_WALK, M_CLEAR, M_LOCK} mode_t;
    mode_t m_mode;
    bit    m_db, m_rose, m_pend, m_red_prev;
    bit    m_raw[$];
    bit    m_win[$];
    int    m_cyc = 0;
    int    m_clear_at, m_lock_at;

    always @(posedge clk) begin : model
        bit s, press, flip, rise, fall, err, in_ped, e_walk;
        m_cyc++;
        if (rst) begin
            m_mode = M_IDLE;
            m_db = 0; m_rose = 0; m_pend = 0; m_red_prev = 0;
            m_raw.delete();
            m_raw.push_back(1'b0);
            m_raw.push_back(1'b0);
            m_win.delete();
            exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0});
        end else begin
            // button seen through two register stages, then accepted after DEB agreeing samples
            m_raw.push_back(ped_button);
            s = m_raw.pop_front();
            m_win.push_back(s);
            if (m_win.size() > DEB) void'(m_win.pop_front());
            flip = (m_win.size() == DEB);
            foreach (m_win[i]) if (m_win[i] == m_db) flip = 0;
            press = m_rose;
            m_rose = 0;
            if (flip) begin
                m_db = !m_db;
                m_rose = m_db;
            end
            rise = red && !m_red_prev;
            fall = !red && m_red_prev;
            m_red_prev = red;
            err = (int'(red) + int'(yellow) + int'(green)) > 1;
            case (m_mode)
                M_IDLE: if (press) m_mode = M_REQ;
                M_REQ:  if (rise) m_mode = M_WALK;
                M_WALK: begin
                    if (press) m_pend = 1;
                    if (fall) begin
                        err = 1;
                        m_mode = M_LOCK;
                        m_lock_at = m_cyc;
                    end else if (int'(clock) <= CT) begin
                        m_mode = M_CLEAR;
                        m_clear_at = m_cyc;
                    end
                end
                M_CLEAR: begin
                    if (press) m_pend = 1;
                    if (fall) begin
                        m_mode = M_LOCK;
                        m_lock_at = m_cyc;
                    end
                end
                default: begin
                    if (press) m_pend = 1;
                    if (m_cyc - m_lock_at == LK) begin
                        m_mode = m_pend ? M_REQ : M_IDLE;
                        m_pend = 0;
                    end
                end
            endcase
            in_ped = (m_mode == M_WALK) || (m_mode == M_CLEAR);
            e_walk = (m_mode == M_WALK) ||
                     ((m_mode == M_CLEAR) && (((m_cyc - m_clear_at) / FD) % 2 == 0));
            exp_q.push_back({(m_mode == M_REQ), e_walk, !in_ped,
                             (m_mode == M_REQ) || m_pend,
                             in_ped ? clock : 8'd0, err});
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : scoreboard
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pass_request", pass_request, e[12]);
            check("walk", walk, e[11]);
            check("dont_walk", dont_walk, e[10]);
            check("req_lamp", req_lamp, e[9]);
            check("ped_count", ped_count, e[8:1]);
            check("seq_err", seq_err, e[0]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int lat, lat_pr, cnt, ph, left, bleft;
        bit [5:0] flash_pat;
        rst = 1'b1; ped_button = 1'b0; red = 1'b0; yellow = 1'b0; green = 1'b1; clock = 8'd0;
        step(3);
        rst = 1'b0;
        step(1);
        check("reset_dont_walk", dont_walk, 1);
        check("reset_req_lamp", req_lamp, 0);

        // 3-cycle glitch must be rejected
        ped_button = 1'b1;
        step(3);
        ped_button = 1'b0;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            step(1);
            cnt += int'(req_lamp | pass_request);
        end
        check("glitch_no_req", cnt, 0);

        // held press: request visible 7 cycles after first high sample
        ped_button = 1'b1;
        lat = 0; lat_pr = 0;
        for (int n = 1; n <= 12; n++) begin
            step(1);
            if (req_lamp && lat == 0) lat = n;
            if (pass_request && lat_pr == 0) lat_pr = n;
            if (n == 10) ped_button = 1'b0;
        end
        check("req_lamp_latency", lat, 7);
        check("pass_req_latency", lat_pr, 7);

        // red rise starts walk, then flashing clearance
        green = 1'b0; yellow = 1'b1; clock = 8'd3;
        step(3);
        yellow = 1'b0; red = 1'b1; clock = 8'd10;
        step(1);
        check("walk_start", walk, 1);
        check("pass_req_drop", pass_request, 0);
        check("walk_count", ped_count, 10);
        for (int c = 9; c >= 6; c--) begin
            clock = 8'(c);
            step(1);
        end
        flash_pat = 6'b110011;
        for (int i = 0; i < 6; i++) begin
            clock = 8'(5 - i);
            step(1);
            check("flash_walk", walk, flash_pat[5 - i]);
            check("flash_dont_walk", dont_walk, 0);
            check("flash_count", ped_count, 5 - i);
        end

        // press during clearance, serviced after lockout
        ped_button = 1'b1;
        step(8);
        ped_button = 1'b0;
        check("clear_press_lamp", req_lamp, 1);
        red = 1'b0; green = 1'b1; clock = 8'd20;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            step(1);
            if (n == 1) check("lockout_dont_walk", dont_walk, 1);
            if (pass_request && lat == 0) lat = n;
        end
        check("lockout_exit", lat, LK + 1);

        // red falling during walk is a sequence error
        green = 1'b0; yellow = 1'b1;
        step(2);
        yellow = 1'b0; red = 1'b1; clock = 8'd20;
        step(1);
        check("walk2_start", walk, 1);
        red = 1'b0;
        step(1);
        check("abort_err", seq_err, 1);
        check("abort_dont_walk", dont_walk, 1);
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            step(1);
            cnt += int'(seq_err);
        end
        check("abort_err_once", cnt, 0);

        // press while red already high: no walk until a fresh red rise
        red = 1'b1; clock = 8'd30;
        step(3);
        ped_button = 1'b1;
        step(10);
        ped_button = 1'b0;
        check("mid_red_req", pass_request, 1);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            step(1);
            cnt += int'(walk);
        end
        check("mid_red_no_walk", cnt, 0);
        red = 1'b0;
        step(2);
        red = 1'b1; clock = 8'd15;
        step(1);
        check("fresh_red_walk", walk, 1);

        // overlapping lamps flag an error without disturbing the walk
        green = 1'b1;
        step(1);
        check("overlap_err", seq_err, 1);
        green = 1'b0;
        cnt = 0;
        for (int n = 0; n < 3; n++) begin
            step(1);
            cnt += int'(seq_err);
        end
        check("overlap_err_once", cnt, 0);
        check("overlap_walk_kept", walk, 1);
        red = 1'b0;
        step(6);

        // randomized traffic: lamp cycle with countdown, random button levels, rare resets
        ph = 2; left = 0; bleft = 20;
        for (int n = 0; n < 4000; n++) begin
            if (left == 0) begin
                ph = (ph + 1) % 3;
                left = (ph == 0) ? int'($urandom_range(5, 30)) :
                       (ph == 1) ? int'($urandom_range(2, 5)) : int'($urandom_range(6, 30));
            end
            left--;
            green = (ph == 0); yellow = (ph == 1); red = (ph == 2);
            clock = 8'(left);
            if ($urandom_range(0, 59) == 0) green = 1'b1;
            if (bleft == 0) begin
                ped_button = ~ped_button;
                bleft = ped_button ? int'($urandom_range(1, 12)) : int'($urandom_range(3, 60));
            end
            bleft--;
            rst = ($urandom_range(0, 799) == 0);
            step(1);
        end
        rst = 1'b0;
        step(3);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
